spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data-phase bits per frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address-phase bits per frame; the address MSB is the read flag (1 = read).
REQ-003 SHALL have port sys_clk  in  1  single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port spi_cs  in  1  chip select, active-low, asynchronous to sys_clk.
REQ-006 SHALL have port spi_sck  in  1  SPI clock from the master, asynchronous.
REQ-007 SHALL have port spi_mosi  in  1  serial data from the master, MSB first.
REQ-008 SHALL have port spi_miso  out  1  serial data to the master, MSB first.
REQ-009 SHALL have ports CPOL and CPHA  in  1 each  SPI mode, latched at frame start.
REQ-010 SHALL have port wr_en  out  1  one-cycle write strobe.
REQ-011 SHALL have ports wr_addr  out  ADDR_WIDTH and wr_data  out  DATA_WIDTH  write address and data, valid while wr_en=1.
REQ-012 SHALL have port rd_req  out  1  one-cycle read request.
REQ-013 SHALL have port rd_addr  out  ADDR_WIDTH  read address, valid from rd_req until frame end.
REQ-014 SHALL have port rd_data  in  DATA_WIDTH  read data, sampled exactly 2 cycles after rd_req.
REQ-015 SHALL have port busy  out  1  high while a frame is in progress.
REQ-016 SHALL have port frame_err  out  1  one-cycle pulse on a malformed frame.

Function
REQ-017 SHALL pass spi_cs, spi_sck and spi_mosi each through a 2-flop synchronizer; all edge detection uses the synchronized values and their one-cycle-delayed copies.
REQ-018 SHALL define the leading edge as a synchronized SCK change away from the latched CPOL, and the trailing edge as a change back to it.
REQ-019 SHALL sample MOSI on leading edges when CPHA=0 and on trailing edges when CPHA=1.
REQ-020 SHALL launch a new MISO bit on trailing edges when CPHA=0 and on leading edges when CPHA=1.
REQ-021 SHALL implement states IDLE, ADDR, FETCH, DATA and DONE.
REQ-022 In IDLE, on a synchronized CS falling edge, SHALL latch CPOL and CPHA, clear the bit counter and the shift registers, set busy=1, and go to ADDR.
REQ-023 In ADDR, SHALL shift sampled bits into the address register; after sample number ADDR_WIDTH, SHALL go to FETCH if address MSB=1, else to DATA.
REQ-024 FETCH SHALL last exactly 2 cycles: rd_req=1 and rd_addr driven in cycle 1; rd_data loaded into the transmit shifter at the end of cycle 2; then go to DATA.
REQ-025 In DATA, SHALL drive spi_miso from the transmit shifter MSB on reads and shift at each launch edge; SHALL shift sampled MOSI into the receive register.
REQ-026 SHALL hold spi_miso=0 in IDLE, ADDR, FETCH and DONE, and for the whole of write frames.
REQ-027 SHALL count sample edges in a 6-bit counter that saturates at ADDR_WIDTH+DATA_WIDTH+1.
REQ-028 On a synchronized CS rising edge in any non-IDLE state, SHALL go to DONE for one cycle, then IDLE, with busy=0 from IDLE.
REQ-029 In DONE, for a write frame with count = ADDR_WIDTH+DATA_WIDTH, SHALL pulse wr_en with wr_addr and wr_data.
REQ-030 In DONE, for count ≠ 0 and ≠ ADDR_WIDTH+DATA_WIDTH, SHALL pulse frame_err and SHALL NOT pulse wr_en; a frame with count=0 is silently ignored.
REQ-031 Correct operation SHALL require an SCK half-period of at least 6 sys_clk cycles, which guarantees the FETCH data is loaded before the first data-bit launch.
REQ-032 SHALL ignore SCK edges while CS is deasserted.

Reset
REQ-033 With rst_n=0 at a clock edge, SHALL enter IDLE and set spi_miso, wr_en, rd_req, busy and frame_err to 0, wr_addr, rd_addr and wr_data to 0, all shifters to 0, and the counter to 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no wr_en or frame_err; after release, the block SHALL wait for a new CS falling edge.

Verification
REQ-035 Mode 0, write addr 0x12, data 0xA5C3, 24 clocks -> one wr_en pulse, wr_addr=0x12, wr_data=0xA5C3, frame_err=0, miso=0 throughout.
REQ-036 Mode 3, read addr 0x85, rd_data=0x1234 -> one rd_req pulse with rd_addr=0x85; the master captures 0x1234 on miso; no wr_en.
REQ-037 Mode 1, write addr 0x7F, data 0xFFFF; then mode 2, write addr 0x00, data 0x0001 -> two wr_en pulses with correct values; CPOL/CPHA latched per frame.
REQ-038 CS released after 10 bits -> frame_err pulse, no wr_en; a following valid frame completes normally.
REQ-039 25 SCK periods within one CS window -> frame_err pulse, no wr_en.
REQ-040 rst_n=0 at bit 12 of a write -> all outputs at reset values, no wr_en; the next full frame writes correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI target bridging a master onto a register bus. It uses a CPOL/CPHA mode chosen per frame
// and an address-then-data frame, where the address MSB selects read.
module spi_slave #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  spi_cs,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic                  CPOL,
  input  logic                  CPHA,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  frame_err
);

  // state | meaning
  // IDLE  | waiting for CS to fall
  // ADDR  | shifting in the address bits
  // FETCH | two cycles: issue rd_req, then load rd_data into the transmit shifter
  // DATA  | shifting data in and, on reads, out
  // DONE  | one cycle: commit the write or flag a malformed frame
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_FETCH, S_DATA, S_DONE} state_t;

  localparam logic [5:0] A_LAST = 6'(ADDR_WIDTH - 1);
  localparam logic [5:0] A_CNT  = 6'(ADDR_WIDTH);
  localparam logic [5:0] FULL   = 6'(ADDR_WIDTH + DATA_WIDTH);
  localparam logic [5:0] LIMIT  = 6'(ADDR_WIDTH + DATA_WIDTH + 1);

  state_t                state_q;
  logic [2:0]            cs_q, sck_q;
  logic [1:0]            mosi_q;
  logic                  cpol_q, cpha_q, rd_q, fetch_q;
  logic [5:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q, wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] rx_q, tx_q, wr_data_q;
  logic                  wr_en_q, rd_req_q, busy_q, frame_err_q;

  logic                  cs_fall, cs_rise, sck_chg, lead, trail, sample, launch;
  logic [5:0]            cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] rx_d;

  // index 1 is the synchronized value, index 2 its one-cycle-delayed copy
  assign cs_fall = cs_q[2] & ~cs_q[1];
  assign cs_rise = ~cs_q[2] & cs_q[1];
  assign sck_chg = (sck_q[2] ^ sck_q[1]) & ~cs_q[1];
  assign lead    = sck_chg & (sck_q[1] != cpol_q);
  assign trail   = sck_chg & (sck_q[1] == cpol_q);
  assign sample  = cpha_q ? trail : lead;
  assign launch  = cpha_q ? lead : trail;
  assign cnt_d   = (cnt_q == LIMIT) ? cnt_q : cnt_q + 6'd1;
  assign addr_d  = {addr_q[ADDR_WIDTH-2:0], mosi_q[1]};
  assign rx_d    = {rx_q[DATA_WIDTH-2:0], mosi_q[1]};

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cs_q        <= '0;
      sck_q       <= '0;
      mosi_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      rd_q        <= 1'b0;
      fetch_q     <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cs_q        <= {cs_q[1:0], spi_cs};
      sck_q       <= {sck_q[1:0], spi_sck};
      mosi_q      <= {mosi_q[0], spi_mosi};
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cs_fall) begin
          cpol_q  <= CPOL;
          cpha_q  <= CPHA;
          cnt_q   <= '0;
          addr_q  <= '0;
          rx_q    <= '0;
          tx_q    <= '0;
          rd_q    <= 1'b0;
          fetch_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_ADDR;
        end
        S_ADDR: if (cs_rise) begin
          state_q <= S_DONE;
        end else if (sample) begin
          addr_q <= addr_d;
          cnt_q  <= cnt_d;
          if (cnt_q == A_LAST) begin
            rd_q <= addr_d[ADDR_WIDTH-1];
            if (addr_d[ADDR_WIDTH-1]) begin
              rd_req_q  <= 1'b1;
              rd_addr_q <= addr_d;
              state_q   <= S_FETCH;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_FETCH: if (cs_rise) begin
          state_q <= S_DONE;
        end else begin
          if (sample) cnt_q <= cnt_d;
          if (!fetch_q) begin
            fetch_q <= 1'b1;
          end else begin
            tx_q    <= rd_data;
            state_q <= S_DATA;
          end
        end
        S_DATA: if (cs_rise) begin
          state_q <= S_DONE;
        end else begin
          if (sample) begin
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
          end
          // the first launch edge of the data phase presents the already-loaded MSB
          if (launch && rd_q && cnt_q > A_CNT) tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
        S_DONE: begin
          if (!rd_q && cnt_q == FULL) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= rx_q;
          end else if (cnt_q != 6'd0 && cnt_q != FULL) begin
            frame_err_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi_miso  = (state_q == S_DATA && rd_q) ? tx_q[DATA_WIDTH-1] : 1'b0;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule
